pipeline_registers_capture: RTL and testbench

- Capture-side counterpart of pipeline_registers_set: a BIT_WIDTH x NUMBER_OF_STAGES shift pipeline whose full contents are snapshotted on request.
- The snapshot is presented as one packed word over a valid/ready handshake.
- Packing matches the set_data layout (stage 0 at LSBs), so a captured word fed to a set block restores the pipeline exactly.
- Used for pipeline state save/restore, debug readout and scan-style observation.

---
 rtl/pipeline_registers_capture_pkg.sv | 13 +
 rtl/pipeline_capture_hold.sv | 72 +++++++
 rtl/pipeline_registers_capture.sv | 81 ++++++++
 tb/tb_pipeline_registers_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_registers_capture_pkg.sv
// Shared types for the capture pipeline: snapshot FSM states and the fill counter width helper.
package pipeline_registers_capture_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } cap_state_e;

   function automatic int count_width(input int stages);
      return $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/pipeline_capture_hold.sv
// Snapshot register with a valid/ready handshake and a one-cycle miss pulse for rejected requests.
// The can_accept input is how the top level selects full-only or partial capture.
module pipeline_capture_hold
   import pipeline_registers_capture_pkg::*;
#(
   parameter int TOTAL_WIDTH = 32
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   capture,
   input  logic                   can_accept,
   input  logic                   capture_ready,
   input  logic [TOTAL_WIDTH-1:0] snap_in,
   output logic [TOTAL_WIDTH-1:0] capture_data,
   output logic                   capture_valid,
   output logic                   capture_miss
);

   cap_state_e             state_reg, state_next;
   logic [TOTAL_WIDTH-1:0] data_reg, data_next;
   logic                   miss_reg, miss_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         miss_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         miss_reg  <= miss_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      miss_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (capture) begin
               if (can_accept) begin
                  state_next = HOLD;
                  data_next  = snap_in;
               end else begin
                  miss_next = 1'b1;
               end
            end
         end
         HOLD: begin
            // A handshake frees the slot in the same cycle, so a new request can reload it.
            if (capture_ready) begin
               if (capture && can_accept) begin
                  data_next = snap_in;
               end else begin
                  state_next = IDLE;
                  miss_next  = capture;
               end
            end else begin
               miss_next = capture;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign capture_data  = data_reg;
   assign capture_valid = (state_reg == HOLD);
   assign capture_miss  = miss_reg;

endmodule

// File: rtl/pipeline_registers_capture.sv
// Shift pipeline with a fill counter and a handshaked full-contents snapshot (stage 0 at LSBs).
// Define PIPELINE_REGISTERS_CAPTURE_PARTIAL_EN to allow snapshots before the pipeline is full.
module pipeline_registers_capture
   import pipeline_registers_capture_pkg::*;
#(
   parameter int  BIT_WIDTH        = 8,
   parameter int  NUMBER_OF_STAGES = 4,
   localparam int FILL_W           = count_width(NUMBER_OF_STAGES),
   localparam int TOTAL_W          = BIT_WIDTH * NUMBER_OF_STAGES
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               shift_en,
   input  logic [BIT_WIDTH-1:0] pipe_in,
   output logic [BIT_WIDTH-1:0] pipe_out,
   input  logic               capture,
   output logic [TOTAL_W-1:0] capture_data,
   output logic               capture_valid,
   input  logic               capture_ready,
   output logic               capture_miss,
   output logic               full,
   output logic [FILL_W-1:0]  fill_count
);

   logic [TOTAL_W-1:0] stages_reg;
   logic [TOTAL_W-1:0] shift_src;
   logic [FILL_W-1:0]  fill_reg;
   logic               can_accept;

   // Stages are kept in the snapshot layout so the capture path is a plain copy.
   assign shift_src[BIT_WIDTH-1:0] = pipe_in;

   genvar gi;
   generate
      for (gi = 1; gi < NUMBER_OF_STAGES; gi++) begin : g_link
         assign shift_src[gi*BIT_WIDTH +: BIT_WIDTH] = stages_reg[(gi-1)*BIT_WIDTH +: BIT_WIDTH];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stages_reg <= '0;
      end else if (shift_en) begin
         stages_reg <= shift_src;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_reg <= '0;
      end else if (shift_en && !full) begin
         fill_reg <= fill_reg + 1'b1;
      end
   end

   assign full       = (fill_reg == FILL_W'(NUMBER_OF_STAGES));
   assign fill_count = fill_reg;
   assign pipe_out   = stages_reg[(NUMBER_OF_STAGES-1)*BIT_WIDTH +: BIT_WIDTH];

`ifdef PIPELINE_REGISTERS_CAPTURE_PARTIAL_EN
   assign can_accept = 1'b1;
`else
   assign can_accept = full;
`endif

   pipeline_capture_hold #(
      .TOTAL_WIDTH (TOTAL_W)
   ) u_hold (
      .clk           (clk),
      .reset         (reset),
      .capture       (capture),
      .can_accept    (can_accept),
      .capture_ready (capture_ready),
      .snap_in       (stages_reg),
      .capture_data  (capture_data),
      .capture_valid (capture_valid),
      .capture_miss  (capture_miss)
   );

endmodule

// File: tb/tb_pipeline_registers_capture.sv
// Self-checking bench: fixed vector table, hand-written corner sequences, and random traffic
// checked against a history-queue model of the pipeline and snapshot slot.
module tb_pipeline_registers_capture;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int TW = W * N;
   localparam int CW = $clog2(N + 1);
`ifdef PIPELINE_REGISTERS_CAPTURE_PARTIAL_EN
   localparam bit PARTIAL = 1'b1;
`else
   localparam bit PARTIAL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          shift_en = 1'b0;
   logic          capture = 1'b0;
   logic          capture_ready = 1'b0;
   logic [W-1:0]  pipe_in = '0;
   logic [W-1:0]  pipe_out;
   logic [TW-1:0] capture_data;
   logic          capture_valid;
   logic          capture_miss;
   logic          full;
   logic [CW-1:0] fill_count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   pipeline_registers_capture #(
      .BIT_WIDTH        (W),
      .NUMBER_OF_STAGES (N)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .shift_en      (shift_en),
      .pipe_in       (pipe_in),
      .pipe_out      (pipe_out),
      .capture       (capture),
      .capture_data  (capture_data),
      .capture_valid (capture_valid),
      .capture_ready (capture_ready),
      .capture_miss  (capture_miss),
      .full          (full),
      .fill_count    (fill_count)
   );

   typedef struct {
      logic          sh;
      logic [W-1:0]  din;
      logic          cap;
      logic          rdy;
      int            fill;
      logic          valid;
      logic [TW-1:0] data;
      logic          miss;
      logic [W-1:0]  pout;
   } vec_t;

   vec_t vecs [12];

   // Reference model: most recent shifted value first, at most N entries.
   logic [W-1:0]  hist [$];
   logic          m_held;
   logic [TW-1:0] m_data;
   logic          m_miss;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input logic sh, input logic [W-1:0] d, input logic cap, input logic rdy);
      shift_en      = sh;
      pipe_in       = d;
      capture       = cap;
      capture_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [TW-1:0] m_snap();
      logic [TW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         if (i < hist.size()) v[i*W +: W] = hist[i];
      return v;
   endfunction

   task automatic m_reset();
      hist.delete();
      m_held = 1'b0;
      m_data = '0;
      m_miss = 1'b0;
   endtask

   task automatic m_step(input logic sh, input logic [W-1:0] d, input logic cap, input logic rdy);
      logic ok;
      ok = cap && (PARTIAL || hist.size() == N);
      if (!m_held) begin
         if (ok) begin
            m_held = 1'b1;
            m_data = m_snap();
         end
         m_miss = cap && !ok;
      end else if (rdy) begin
         if (ok) m_data = m_snap();
         else m_held = 1'b0;
         m_miss = cap && !ok;
      end else begin
         m_miss = cap;
      end
      if (sh) begin
         hist.push_front(d);
         if (hist.size() > N) void'(hist.pop_back());
      end
   endtask

   initial begin
      // Fill, capture, hold through shifting, then release.
      vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b0, 32'h0,        1'b0, 8'h00};
      vecs[1]  = '{1'b1, 8'h23, 1'b0, 1'b0, 2, 1'b0, 32'h0,        1'b0, 8'h00};
      vecs[2]  = '{1'b1, 8'h45, 1'b0, 1'b0, 3, 1'b0, 32'h0,        1'b0, 8'h00};
      vecs[3]  = '{1'b1, 8'h67, 1'b0, 1'b0, 4, 1'b0, 32'h0,        1'b0, 8'h01};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b1, 32'h01234567, 1'b0, 8'h01};
      vecs[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 4, 1'b1, 32'h01234567, 1'b0, 8'h23};
      vecs[6]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 4, 1'b1, 32'h01234567, 1'b0, 8'h45};
      vecs[7]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 4, 1'b1, 32'h01234567, 1'b0, 8'h67};
      vecs[8]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 4, 1'b1, 32'h01234567, 1'b0, 8'hAA};
      vecs[9]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 4, 1'b1, 32'h01234567, 1'b0, 8'hAA};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b0, 32'h01234567, 1'b0, 8'hAA};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b0, 32'h01234567, 1'b0, 8'hAA};

      // Reset state, observed while reset is still held.
      #2;
      chk("rst_valid", capture_valid, 1'b0);
      chk("rst_data", capture_data, '0);
      chk("rst_miss", capture_miss, 1'b0);
      chk("rst_fill", fill_count, 0);
      chk("rst_full", full, 1'b0);
      chk("rst_pout", pipe_out, '0);
      tick();
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].sh, vecs[i].din, vecs[i].cap, vecs[i].rdy);
         tick();
         $display("vec %0d: sh=%0d in=%h cap=%0d rdy=%0d -> valid=%0d data=%h miss=%0d fill=%0d pout=%h",
                  i, vecs[i].sh, vecs[i].din, vecs[i].cap, vecs[i].rdy,
                  capture_valid, capture_data, capture_miss, fill_count, pipe_out);
         chk($sformatf("v%0d_fill", i), fill_count, vecs[i].fill);
         chk($sformatf("v%0d_full", i), full, vecs[i].fill == N);
         chk($sformatf("v%0d_valid", i), capture_valid, vecs[i].valid);
         chk($sformatf("v%0d_data", i), capture_data, vecs[i].data);
         chk($sformatf("v%0d_miss", i), capture_miss, vecs[i].miss);
         chk($sformatf("v%0d_pout", i), pipe_out, vecs[i].pout);
      end

      // Capture request on a half-filled pipeline.
      do_reset();
      drive(1'b1, 8'h01, 1'b0, 1'b0); tick();
      drive(1'b1, 8'h23, 1'b0, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      $display("partial capture: valid=%0d data=%h miss=%0d", capture_valid, capture_data, capture_miss);
`ifdef PIPELINE_REGISTERS_CAPTURE_PARTIAL_EN
      chk("part_valid", capture_valid, 1'b1);
      chk("part_data", capture_data, 32'h00000123);
      chk("part_miss", capture_miss, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
      chk("part_valid2", capture_valid, 1'b1);
      chk("part_miss2", capture_miss, 1'b0);
`else
      chk("part_miss", capture_miss, 1'b1);
      chk("part_valid", capture_valid, 1'b0);
      chk("part_fill", fill_count, 2);
      drive(1'b0, 8'h00, 1'b0, 1'b0); tick();
      chk("part_miss2", capture_miss, 1'b0);
      chk("part_valid2", capture_valid, 1'b0);
`endif

      // Miss while holding, then back-to-back reload on handshake.
      do_reset();
      drive(1'b1, 8'h01, 1'b0, 1'b0); tick();
      drive(1'b1, 8'h23, 1'b0, 1'b0); tick();
      drive(1'b1, 8'h45, 1'b0, 1'b0); tick();
      drive(1'b1, 8'h67, 1'b0, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      chk("hold_valid", capture_valid, 1'b1);
      chk("hold_data", capture_data, 32'h01234567);
      drive(1'b1, 8'h89, 1'b1, 1'b0); tick();
      $display("hold miss: valid=%0d data=%h miss=%0d", capture_valid, capture_data, capture_miss);
      chk("hold_miss", capture_miss, 1'b1);
      chk("hold_data2", capture_data, 32'h01234567);
      chk("hold_valid2", capture_valid, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 1'b1); tick();
      $display("b2b reload: valid=%0d data=%h miss=%0d", capture_valid, capture_data, capture_miss);
      chk("b2b_valid", capture_valid, 1'b1);
      chk("b2b_data", capture_data, 32'h23456789);
      chk("b2b_miss", capture_miss, 1'b0);

      // Asynchronous reset between edges while holding.
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      $display("async reset: valid=%0d data=%h fill=%0d pout=%h", capture_valid, capture_data, fill_count, pipe_out);
      chk("arst_valid", capture_valid, 1'b0);
      chk("arst_data", capture_data, '0);
      chk("arst_fill", fill_count, 0);
      chk("arst_pout", pipe_out, '0);
      tick();
      reset = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
      chk("arst_idle", capture_valid, 1'b0);
      chk("arst_miss", capture_miss, 1'b0);

      // Over-filling saturates the counter; capture sees the last four values.
      do_reset();
      begin
         int fill_exp [6] = '{1, 2, 3, 4, 4, 4};
         logic [W-1:0] pout_exp [6] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h12};
         for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'h10 + W'(k), 1'b0, 1'b0); tick();
            chk($sformatf("sat_fill%0d", k), fill_count, fill_exp[k]);
            chk($sformatf("sat_pout%0d", k), pipe_out, pout_exp[k]);
         end
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      $display("sat capture: valid=%0d data=%h", capture_valid, capture_data);
      chk("sat_valid", capture_valid, 1'b1);
      chk("sat_data", capture_data, 32'h12131415);
      drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
      chk("sat_release", capture_valid, 1'b0);

      // Random traffic against the model.
      do_reset();
      m_reset();
      for (int c = 0; c < 1500; c++) begin
         logic          sh, cap, rdy;
         logic [W-1:0]  d;
         logic          was_held;
         sh  = 1'($urandom_range(0, 1));
         cap = ($urandom_range(0, 2) == 0);
         rdy = 1'($urandom_range(0, 1));
         d   = W'($urandom);
         was_held = m_held;
         drive(sh, d, cap, rdy);
         m_step(sh, d, cap, rdy);
         tick();
         if (was_held && rdy)
            $display("rnd %0d: handshake data=%h next_valid=%0d", c, capture_data, capture_valid);
         chk("rnd_fill", fill_count, hist.size());
         chk("rnd_full", full, hist.size() == N);
         chk("rnd_pout", pipe_out, (hist.size() == N) ? hist[N-1] : '0);
         chk("rnd_valid", capture_valid, m_held);
         chk("rnd_data", capture_data, m_data);
         chk("rnd_miss", capture_miss, m_miss);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
